mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/lc3b_types.sv | 18 +
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
`default_nettype none
// ============================================================================
// Package     : lc3b_types
// Description : Shared LC-3b word type and memory-arbiter state encoding.
// Revision    : 1.0
// ============================================================================
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } lc3b_arb_state;

endpackage : lc3b_types
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port (instruction/data) arbiter onto one shared memory
//               port, data-priority with bounded instruction starvation.
// Revision    : 1.0
// ============================================================================
module mem_arbiter
    import lc3b_types::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       i_read,
    input  lc3b_word   i_addr,
    output lc3b_word   i_rdata,
    output logic       i_resp,

    input  logic       d_read,
    input  logic       d_write,
    input  lc3b_word   d_addr,
    input  lc3b_word   d_wdata,
    input  logic [1:0] d_byte_en,
    output lc3b_word   d_rdata,
    output logic       d_resp,

    output logic       m_read,
    output logic       m_write,
    output lc3b_word   m_addr,
    output lc3b_word   m_wdata,
    output logic [1:0] m_byte_en,
    input  lc3b_word   m_rdata,
    input  logic       m_resp
);

    localparam int                 c_CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

    lc3b_arb_state      state_q,  state_d;
    logic [c_CNT_W-1:0] starve_q, starve_d;
    lc3b_word           addr_q,   addr_d;
    lc3b_word           wdata_q,  wdata_d;
    logic [1:0]         ben_q,    ben_d;
    logic               write_q,  write_d;

    logic w_d_req;
    logic w_grant_d;
    logic w_i_own;
    logic w_d_own;

    assign w_d_req   = d_read | d_write;
    // Data wins ties until the instruction side has waited STARVE_LIMIT grants.
    assign w_grant_d = w_d_req & (~i_read | (starve_q != c_LIMIT));

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ben_d    = ben_q;
        write_d  = write_q;
        case (state_q)
            IDLE: begin
                if (w_grant_d) begin
                    state_d = D_BUSY;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    ben_d   = d_byte_en;
                    write_d = d_write;
                    if (!i_read)
                        starve_d = '0;
                    else if (starve_q != c_LIMIT)
                        starve_d = starve_q + 1'b1;
                end else if (i_read) begin
                    state_d  = I_BUSY;
                    addr_d   = i_addr;
                    wdata_d  = '0;
                    ben_d    = '0;
                    write_d  = 1'b0;
                    starve_d = '0;
                end
            end
            I_BUSY, D_BUSY: begin
                if (m_resp)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            starve_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ben_q    <= '0;
            write_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ben_q    <= ben_d;
            write_q  <= write_d;
        end
    end

    // Memory side is driven purely from the captured request.
    assign w_i_own   = (state_q == I_BUSY);
    assign w_d_own   = (state_q == D_BUSY);
    assign m_read    = w_i_own | (w_d_own & ~write_q);
    assign m_write   = w_d_own & write_q;
    assign m_addr    = addr_q;
    assign m_wdata   = wdata_q;
    assign m_byte_en = ben_q;

    assign i_resp    = w_i_own & m_resp;
    assign d_resp    = w_d_own & m_resp;
    assign i_rdata   = i_resp ? m_rdata : '0;
    assign d_rdata   = d_resp ? m_rdata : '0;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter against a
//               transaction-level model of the arbitration rules.
// Revision    : 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_read;
    logic [15:0] i_addr;
    logic [15:0] i_rdata;
    logic        i_resp;
    logic        d_read;
    logic        d_write;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [1:0]  d_byte_en;
    logic [15:0] d_rdata;
    logic        d_resp;
    logic        m_read;
    logic        m_write;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    logic [1:0]  m_byte_en;
    logic [15:0] m_rdata;
    logic        m_resp;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_read    (i_read),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_resp    (i_resp),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_byte_en (d_byte_en),
        .d_rdata   (d_rdata),
        .d_resp    (d_resp),
        .m_read    (m_read),
        .m_write   (m_write),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_byte_en (m_byte_en),
        .m_rdata   (m_rdata),
        .m_resp    (m_resp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
        end
    endtask

    // Model: owner 0 = none, 1 = instruction, 2 = data.
    int          owner  = 0;
    int          starve = 0;
    logic [15:0] ma     = '0;
    logic [15:0] mwd    = '0;
    logic [1:0]  mbe    = '0;
    logic        mw     = 1'b0;
    string       mlog   = "";
    string       dlog   = "";
    bit          log_en = 1'b0;
    bit          prev_busy = 1'b0;
    int          iresp_cnt = 0;
    int          dresp_cnt = 0;

    task automatic model_reset();
        owner  = 0;
        starve = 0;
        ma     = '0;
        mwd    = '0;
        mbe    = '0;
        mw     = 1'b0;
    endtask

    initial begin : compare
        logic exp_rd, exp_wr, exp_ir, exp_dr, busy;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_reset();
                chk("rst_m_ctrl", {m_read, m_write, m_byte_en, m_addr}, 32'h0);
                chk("rst_m_wdata", m_wdata, 32'h0);
                chk("rst_i_port", {i_resp, i_rdata}, 32'h0);
                chk("rst_d_port", {d_resp, d_rdata}, 32'h0);
            end else begin
                exp_rd = (owner == 1) || (owner == 2 && !mw);
                exp_wr = (owner == 2) && mw;
                chk("m_rw", {m_read, m_write}, {exp_rd, exp_wr});
                if (owner != 0) chk("m_addr", m_addr, ma);
                if (owner == 2) chk("m_wdata_be", {m_byte_en, m_wdata}, {mbe, mwd});
                exp_ir = (owner == 1) && m_resp;
                exp_dr = (owner == 2) && m_resp;
                chk("i_port", {i_resp, i_rdata}, {exp_ir, exp_ir ? m_rdata : 16'h0});
                chk("d_port", {d_resp, d_rdata}, {exp_dr, exp_dr ? m_rdata : 16'h0});
            end
            if (i_resp) iresp_cnt++;
            if (d_resp) dresp_cnt++;
            busy = m_read | m_write;
            if (log_en && busy && !prev_busy)
                dlog = {dlog, (m_addr == 16'h1000) ? "I" : "D"};
            prev_busy = busy;

            @(posedge clk);
            if (!rst_n) begin
                model_reset();
            end else if (owner != 0) begin
                if (m_resp) owner = 0;
            end else if ((d_read || d_write) && (!i_read || starve != LIMIT)) begin
                owner  = 2;
                ma     = d_addr;
                mwd    = d_wdata;
                mbe    = d_byte_en;
                mw     = d_write;
                starve = i_read ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
                if (log_en) mlog = {mlog, "D"};
            end else if (i_read) begin
                owner  = 1;
                ma     = i_addr;
                starve = 0;
                if (log_en) mlog = {mlog, "I"};
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        int saved_dresp;
        rst_n = 1'b0;
        i_read = 1'b0; i_addr = '0;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0; d_byte_en = '0;
        m_rdata = '0; m_resp = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Single fetch, memory answers three cycles after the grant.
        iresp_cnt = 0;
        i_read = 1'b1; i_addr = 16'h0040;
        tick();
        i_read = 1'b0;
        #1 chk("fetch_req", {m_read, m_write, m_addr}, {1'b1, 1'b0, 16'h0040});
        tick(); tick(); tick();
        m_resp = 1'b1; m_rdata = 16'h1234;
        #1 chk("fetch_resp", {i_resp, i_rdata, d_resp}, {1'b1, 16'h1234, 1'b0});
        tick();
        m_resp = 1'b0; m_rdata = '0;
        #1 chk("fetch_idle", {m_read, m_write, i_resp}, 32'h0);
        tick();
        chk("fetch_pulses", iresp_cnt, 32'd1);

        // Store.
        d_write = 1'b1; d_addr = 16'h2002; d_wdata = 16'hBEEF; d_byte_en = 2'b10;
        tick();
        d_write = 1'b0; d_addr = '0; d_wdata = '0; d_byte_en = '0;
        #1 chk("store_req", {m_read, m_write, m_byte_en, m_addr}, {1'b0, 1'b1, 2'b10, 16'h2002});
        chk("store_wdata", m_wdata, 32'h0000BEEF);
        tick();
        m_resp = 1'b1;
        #1 chk("store_resp", {d_resp, i_resp}, 32'h2);
        tick();
        m_resp = 1'b0;
        tick();

        // Read and write together is a write.
        d_read = 1'b1; d_write = 1'b1; d_addr = 16'h0A0A;
        tick();
        d_read = 1'b0; d_write = 1'b0;
        #1 chk("rw_both", {m_read, m_write}, 32'h1);
        m_resp = 1'b1;
        tick();
        m_resp = 1'b0;
        tick();

        // Requester address changes under an active transaction.
        d_read = 1'b1; d_addr = 16'h3000;
        tick();
        d_addr = 16'h4000;
        #1 chk("hold_addr0", m_addr, 32'h3000);
        tick();
        chk("hold_addr1", {m_read, m_addr}, {1'b1, 16'h3000});
        m_resp = 1'b1; m_rdata = 16'hCAFE;
        #1 chk("hold_resp", {d_resp, d_rdata, m_addr}, {1'b1, 16'hCAFE, 16'h3000});
        d_read = 1'b0;
        tick();
        m_resp = 1'b0; m_rdata = '0;
        tick();

        // Starvation bound with both requesters held.
        i_addr = 16'h1000; d_addr = 16'h2000;
        mlog = ""; dlog = ""; log_en = 1'b1;
        i_read = 1'b1; d_read = 1'b1; m_resp = 1'b1; m_rdata = 16'h5A5A;
        repeat (14) tick();
        i_read = 1'b0; d_read = 1'b0;
        tick();
        log_en = 1'b0; m_resp = 1'b0; m_rdata = '0;
        tick();
        chk_str("grant_order_model", mlog.substr(0, 5), "DDDDID");
        chk_str("grant_order_dut", dlog.substr(0, 5), "DDDDID");

        // Reset during a data transaction.
        saved_dresp = dresp_cnt;
        d_write = 1'b1; d_addr = 16'h5000; d_wdata = 16'h1111; d_byte_en = 2'b11;
        tick();
        d_write = 1'b0;
        #1 chk("rst_pre", m_write, 32'h1);
        #1 rst_n = 1'b0;
        m_resp = 1'b1;
        #1 chk("rst_async", {m_write, m_read, d_resp, m_addr}, 32'h0);
        i_read = 1'b1; i_addr = 16'h0100;
        tick();
        m_resp = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        #1 chk("post_rst_grant", {m_read, m_write, m_addr}, {1'b1, 1'b0, 16'h0100});
        i_read = 1'b0;
        m_resp = 1'b1; m_rdata = 16'h7777;
        #1 chk("post_rst_resp", {i_resp, i_rdata}, {1'b1, 16'h7777});
        tick();
        m_resp = 1'b0; m_rdata = '0;
        tick();
        chk("rst_no_dresp", dresp_cnt, saved_dresp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
